// File: rtl/sccb_master_rw.sv
// SCCB/I2C-style register master for camera setup: 3-phase writes and
// 2-phase-write + 2-phase-read register reads, open-drain SDA.
// Ports: clk, rst (async, active-high), start/rw/dev_addr/reg_addr/wr_data
//   request inputs latched on accept; rd_data, ready, done_tick, ack_err
//   status; scl push-pull clock; sda open-drain data.
module sccb_master_rw #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SCCB_FREQ  = 100_000,
  parameter int ADDR_BYTES = 1,
  parameter int STOP_DELAY = 50,
  parameter int CHECK_ACK  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    rw,
  input  logic [6:0]              dev_addr,
  input  logic [8*ADDR_BYTES-1:0] reg_addr,
  input  logic [7:0]              wr_data,
  output logic [7:0]              rd_data,
  output logic                    ready,
  output logic                    done_tick,
  output logic                    ack_err,
  output logic                    scl,
  inout  wire                     sda
);

  localparam int QDIV = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW   = $clog2(QDIV + 1);
  localparam int DW   = $clog2(STOP_DELAY + 1);
  localparam int FW   = 8 * (2 + ADDR_BYTES);

  if (QDIV < 1) begin : g_qdiv_chk
    $error("sccb_master_rw: QDIV must be >= 1");
  end
  if (STOP_DELAY < 1 || ADDR_BYTES < 1 || ADDR_BYTES > 2) begin : g_par_chk
    $error("sccb_master_rw: bad STOP_DELAY or ADDR_BYTES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TX_BYTE, S_TX_ACK,
    S_RX_BYTE, S_RX_NACK, S_STOP, S_DELAY
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      quar_q, quar_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [6:0]      dev_q, dev_d;
  logic            rw_q, rw_d;
  logic            ph_q, ph_d;
  logic            abort_q, abort_d;
  logic            nack_q, nack_d;
  logic            err_q, err_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rd_q, rd_d;

  logic       sda_in;
  logic       sda_low;
  logic       qend, bend, samp, dlast;
  logic       done;
  logic [2:0] nbytes;

  assign sda_in = sda;
  assign sda    = sda_low ? 1'b0 : 1'bz;

  assign qend  = (qcnt_q == QW'(QDIV - 1));
  assign bend  = qend && (quar_q == 2'd3);
  assign samp  = qend && (quar_q == 2'd2);
  assign dlast = (dcnt_q == DW'(STOP_DELAY - 1));

  // Bytes in the current frame; the read phase carries only the address.
  assign nbytes = ph_q ? 3'd1 :
                  rw_q ? 3'(1 + ADDR_BYTES) : 3'(2 + ADDR_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      quar_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      dcnt_q  <= '0;
      frame_q <= '0;
      dev_q   <= '0;
      rw_q    <= 1'b0;
      ph_q    <= 1'b0;
      abort_q <= 1'b0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      quar_q  <= quar_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      dcnt_q  <= dcnt_d;
      frame_q <= frame_d;
      dev_q   <= dev_d;
      rw_q    <= rw_d;
      ph_q    <= ph_d;
      abort_q <= abort_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    quar_d  = quar_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    dcnt_d  = dcnt_q;
    frame_d = frame_q;
    dev_d   = dev_q;
    rw_d    = rw_q;
    ph_d    = ph_q;
    abort_d = abort_q;
    nack_d  = nack_q;
    err_d   = err_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    done    = 1'b0;

    if (state_q != S_IDLE && state_q != S_DELAY) begin
      if (qend) begin
        qcnt_d = '0;
        quar_d = quar_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          qcnt_d  = '0;
          quar_d  = '0;
          dev_d   = dev_addr;
          rw_d    = rw;
          frame_d = {dev_addr, 1'b0, reg_addr, wr_data};
          err_d   = 1'b0;
          ph_d    = 1'b0;
          abort_d = 1'b0;
        end
      end
      S_START: begin
        if (bend) begin
          state_d = S_TX_BYTE;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_TX_BYTE: begin
        if (bend) begin
          frame_d = frame_q << 1;
          if (bit_q == 3'd7) state_d = S_TX_ACK;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_TX_ACK: begin
        if (samp) begin
          nack_d = sda_in;
          if (sda_in) err_d = 1'b1;
        end
        if (bend) begin
          bit_d = '0;
          if (CHECK_ACK != 0 && nack_q) begin
            abort_d = 1'b1;
            state_d = S_STOP;
          end else if (3'(byte_q + 3'd1) < nbytes) begin
            byte_d  = byte_q + 3'd1;
            state_d = S_TX_BYTE;
          end else if (ph_q) begin
            state_d = S_RX_BYTE;
          end else begin
            state_d = S_STOP;
          end
        end
      end
      S_RX_BYTE: begin
        if (samp) rx_d = {rx_q[6:0], sda_in};
        if (bend) begin
          if (bit_q == 3'd7) state_d = S_RX_NACK;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_RX_NACK: begin
        if (bend) begin
          rd_d    = rx_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bend) begin
          state_d = S_DELAY;
          dcnt_d  = '0;
        end
      end
      S_DELAY: begin
        if (dlast) begin
          // A read that got through its address phase re-starts
          // with the read-direction device byte on top.
          if (rw_q && !ph_q && !abort_q) begin
            state_d = S_START;
            ph_d    = 1'b1;
            qcnt_d  = '0;
            quar_d  = '0;
            frame_d[FW-1 -: 8] = {dev_q, 1'b1};
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode: SCL low in Q0-Q1 of every data/ack bit.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      S_START: sda_low = quar_q[1];
      S_TX_BYTE: begin
        scl     = quar_q[1];
        sda_low = ~frame_q[FW-1];
      end
      S_TX_ACK, S_RX_BYTE, S_RX_NACK: scl = quar_q[1];
      S_STOP: begin
        scl     = quar_q[1];
        sda_low = (quar_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign done_tick = done;
  assign ack_err   = err_q;
  assign rd_data   = rd_q;

endmodule
